// File: rtl/cpu86_bpu_pkg.sv
// Shared types for the 8086 branch prediction unit: decoder event kinds,
// return-address-stack controller states and the default return address width.
package cpu86_bpu_pkg;

    typedef enum logic [1:0] {NONE, CALL, RET, RSVD} bpu_dec_kind_t;

    typedef enum logic [1:0] {IDLE, PRED, FLUSH} ras_state_t;

    localparam int RAS_DW = 32;

endpackage

// File: rtl/cpu86_bpu_ras_ctrl.sv
// Return-address-stack controller: pushes CALL return addresses into the external
// BPU LIFO, pops on RET to offer a predicted target, and drains the LIFO on flush.
//
// state | meaning
// IDLE  | accepting decoder events; CALL pushes, RET pops and moves to PRED
// PRED  | prediction presented, held until fetch acks it
// FLUSH | draining the LIFO after an execute-unit flush
module cpu86_bpu_ras_ctrl
    import cpu86_bpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = RAS_DW,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_vld,
    output logic             dec_ack,
    input  logic [1:0]       dec_kind,
    input  logic [DW-1:0]    dec_ret_addr,
    output logic             pred_vld,
    input  logic             pred_ack,
    output logic             pred_hit,
    output logic [DW-1:0]    pred_data,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic [CNT_W-1:0] occupancy,
    output logic             lifo_push_vld,
    output logic [DW-1:0]    lifo_push_data,
    input  logic             lifo_pop_vld,
    output logic             lifo_pop_ack,
    input  logic [DW-1:0]    lifo_pop_data
);

    ras_state_t       state_q, state_d;
    logic             pred_vld_q, pred_vld_d;
    logic             pred_hit_q, pred_hit_d;
    logic [DW-1:0]    pred_data_q, pred_data_d;
    logic [CNT_W-1:0] occ_q, occ_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pred_vld_q  <= 1'b0;
            pred_hit_q  <= 1'b0;
            pred_data_q <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            pred_vld_q  <= pred_vld_d;
            pred_hit_q  <= pred_hit_d;
            pred_data_q <= pred_data_d;
            occ_q       <= occ_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pred_vld_d    = pred_vld_q;
        pred_hit_d    = pred_hit_q;
        pred_data_d   = pred_data_q;
        occ_d         = occ_q;
        lifo_push_vld = 1'b0;
        lifo_pop_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (dec_vld) begin
                    case (bpu_dec_kind_t'(dec_kind))
                        CALL: begin
                            lifo_push_vld = 1'b1;
                            // At DEPTH the LIFO drops its oldest entry, so the count stays put.
                            if (occ_q != CNT_W'(DEPTH))
                                occ_d = occ_q + CNT_W'(1);
                        end
                        RET: begin
                            if (lifo_pop_vld) begin
                                lifo_pop_ack = 1'b1;
                                pred_hit_d   = 1'b1;
                                pred_data_d  = lifo_pop_data;
                                if (occ_q != '0)
                                    occ_d = occ_q - CNT_W'(1);
                            end else begin
                                pred_hit_d  = 1'b0;
                                pred_data_d = '0;
                            end
                            pred_vld_d = 1'b1;
                            state_d    = PRED;
                        end
                        default: ;
                    endcase
                end
            end
            PRED: begin
                if (flush_req) begin
                    pred_vld_d  = 1'b0;
                    pred_hit_d  = 1'b0;
                    pred_data_d = '0;
                    state_d     = FLUSH;
                end else if (pred_ack) begin
                    pred_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            FLUSH: begin
                lifo_pop_ack = lifo_pop_vld;
                if (lifo_pop_vld) begin
                    if (occ_q != '0)
                        occ_d = occ_q - CNT_W'(1);
                end else begin
                    occ_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dec_ack        = (state_q == IDLE) && !flush_req;
    assign flush_busy     = (state_q == FLUSH);
    assign lifo_push_data = dec_ret_addr;
    assign pred_vld       = pred_vld_q;
    assign pred_hit       = pred_hit_q;
    assign pred_data      = pred_data_q;
    assign occupancy      = occ_q;

    // The counter mirrors the LIFO contents, so a pop from an empty count is a bookkeeping bug.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        lifo_pop_ack |-> (occ_q != '0));

endmodule

// File: tb/tb_cpu86_bpu_ras_ctrl.sv
// Directed bench for the return-address-stack controller with a behavioural
// 16-entry LIFO (push drops oldest when full) attached to the LIFO ports.
module tb_cpu86_bpu_ras_ctrl;
    import cpu86_bpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_vld;
    logic        dec_ack;
    logic [1:0]  dec_kind;
    logic [31:0] dec_ret_addr;
    logic        pred_vld;
    logic        pred_ack;
    logic        pred_hit;
    logic [31:0] pred_data;
    logic        flush_req;
    logic        flush_busy;
    logic [4:0]  occupancy;
    logic        lifo_push_vld;
    logic [31:0] lifo_push_data;
    logic        lifo_pop_vld  = 1'b0;
    logic        lifo_pop_ack;
    logic [31:0] lifo_pop_data = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu86_bpu_ras_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .dec_vld        (dec_vld),
        .dec_ack        (dec_ack),
        .dec_kind       (dec_kind),
        .dec_ret_addr   (dec_ret_addr),
        .pred_vld       (pred_vld),
        .pred_ack       (pred_ack),
        .pred_hit       (pred_hit),
        .pred_data      (pred_data),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
        .occupancy      (occupancy),
        .lifo_push_vld  (lifo_push_vld),
        .lifo_push_data (lifo_push_data),
        .lifo_pop_vld   (lifo_pop_vld),
        .lifo_pop_ack   (lifo_pop_ack),
        .lifo_pop_data  (lifo_pop_data)
    );

    // LIFO model, reset from the same source as the controller
    logic [31:0] lq[$];
    always @(posedge clk) begin
        if (reset) begin
            lq.delete();
        end else begin
            if (lifo_pop_ack && lq.size() > 0) void'(lq.pop_front());
            if (lifo_push_vld) begin
                lq.push_front(lifo_push_data);
                if (lq.size() > 16) void'(lq.pop_back());
            end
        end
        lifo_pop_vld  <= (lq.size() != 0);
        lifo_pop_data <= (lq.size() != 0) ? lq[0] : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [1:0] kind, input logic [31:0] addr,
                         input logic pack, input logic fl);
        @(negedge clk);
        dec_vld = dv; dec_kind = kind; dec_ret_addr = addr; pred_ack = pack; flush_req = fl;
        #1;
    endtask

    task automatic do_call(input logic [31:0] addr);
        drive(1'b1, 2'd1, addr, 1'b0, 1'b0);
        chk("call_ack", 32'(dec_ack), 32'd1);
        chk("call_push", 32'(lifo_push_vld), 32'd1);
        chk("call_push_data", lifo_push_data, addr);
    endtask

    task automatic do_ret(input logic exp_hit, input logic [31:0] exp_data);
        drive(1'b1, 2'd2, 32'h0, 1'b0, 1'b0);
        chk("ret_ack", 32'(dec_ack), 32'd1);
        chk("ret_pop", 32'(lifo_pop_ack), 32'(exp_hit));
        drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        chk("ret_pred_vld", 32'(pred_vld), 32'd1);
        chk("ret_pred_hit", 32'(pred_hit), 32'(exp_hit));
        chk("ret_pred_data", pred_data, exp_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; dec_vld = 0; dec_kind = 0; dec_ret_addr = 0; pred_ack = 0; flush_req = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        dv;
        logic [1:0]  kind;
        logic [31:0] addr;
        logic        pack;
        logic        fl;
        logic        e_ack;
        logic        e_push;
        logic        e_pop;
        logic        e_pv;
        logic        e_hit;
        logic [31:0] e_data;
        logic [4:0]  e_occ;
        logic        e_busy;
    } vec_t;

    localparam logic [31:0] A0 = 32'h1000_0010;
    localparam logic [31:0] AA = 32'h3000_000A;
    localparam logic [31:0] AB = 32'h3000_000B;
    localparam logic [31:0] AC = 32'h3000_000C;

    vec_t vt[20];

    initial begin
        // dv kind addr pack fl | ack push pop pv hit data occ busy
        vt[0]  = '{1, 2'd1, A0,    0, 0, 1, 1, 0, 0, 0, 32'h0, 5'd0, 0};
        vt[1]  = '{1, 2'd2, 32'h0, 0, 0, 1, 0, 1, 0, 0, 32'h0, 5'd1, 0};
        vt[2]  = '{0, 2'd0, 32'h0, 0, 0, 0, 0, 0, 1, 1, A0,    5'd0, 0};
        vt[3]  = '{0, 2'd0, 32'h0, 1, 0, 0, 0, 0, 1, 1, A0,    5'd0, 0};
        vt[4]  = '{0, 2'd0, 32'h0, 0, 0, 1, 0, 0, 0, 1, A0,    5'd0, 0};
        vt[5]  = '{1, 2'd1, AA,    0, 0, 1, 1, 0, 0, 1, A0,    5'd0, 0};
        vt[6]  = '{1, 2'd1, AB,    0, 0, 1, 1, 0, 0, 1, A0,    5'd1, 0};
        vt[7]  = '{1, 2'd1, AC,    0, 0, 1, 1, 0, 0, 1, A0,    5'd2, 0};
        vt[8]  = '{1, 2'd2, 32'h0, 0, 0, 1, 0, 1, 0, 1, A0,    5'd3, 0};
        vt[9]  = '{1, 2'd2, 32'h0, 0, 0, 0, 0, 0, 1, 1, AC,    5'd2, 0};
        vt[10] = '{1, 2'd2, 32'h0, 1, 0, 0, 0, 0, 1, 1, AC,    5'd2, 0};
        vt[11] = '{1, 2'd2, 32'h0, 0, 0, 1, 0, 1, 0, 1, AC,    5'd2, 0};
        vt[12] = '{1, 2'd2, 32'h0, 1, 0, 0, 0, 0, 1, 1, AB,    5'd1, 0};
        vt[13] = '{1, 2'd2, 32'h0, 0, 0, 1, 0, 1, 0, 1, AB,    5'd1, 0};
        vt[14] = '{0, 2'd0, 32'h0, 1, 0, 0, 0, 0, 1, 1, AA,    5'd0, 0};
        vt[15] = '{1, 2'd2, 32'h0, 0, 0, 1, 0, 0, 0, 1, AA,    5'd0, 0};
        vt[16] = '{0, 2'd0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 5'd0, 0};
        vt[17] = '{0, 2'd0, 32'h0, 1, 0, 0, 0, 0, 1, 0, 32'h0, 5'd0, 0};
        vt[18] = '{1, 2'd0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 5'd0, 0};
        vt[19] = '{1, 2'd3, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 5'd0, 0};

        reset = 1'b1; dec_vld = 0; dec_kind = 0; dec_ret_addr = 0; pred_ack = 0; flush_req = 0;
        do_reset();
        #1;
        chk("rst_pred_vld", 32'(pred_vld), 32'd0);
        chk("rst_pred_hit", 32'(pred_hit), 32'd0);
        chk("rst_pred_data", pred_data, 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_busy", 32'(flush_busy), 32'd0);
        chk("rst_push", 32'(lifo_push_vld), 32'd0);
        chk("rst_pop", 32'(lifo_pop_ack), 32'd0);

        // single call/ret, ABC ordering, empty-stack ret, NONE/reserved kinds
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].dv, vt[i].kind, vt[i].addr, vt[i].pack, vt[i].fl);
            chk($sformatf("v%0d_ack", i),  32'(dec_ack),       32'(vt[i].e_ack));
            chk($sformatf("v%0d_push", i), 32'(lifo_push_vld), 32'(vt[i].e_push));
            chk($sformatf("v%0d_pop", i),  32'(lifo_pop_ack),  32'(vt[i].e_pop));
            chk($sformatf("v%0d_pv", i),   32'(pred_vld),      32'(vt[i].e_pv));
            chk($sformatf("v%0d_hit", i),  32'(pred_hit),      32'(vt[i].e_hit));
            chk($sformatf("v%0d_data", i), pred_data,          vt[i].e_data);
            chk($sformatf("v%0d_occ", i),  32'(occupancy),     32'(vt[i].e_occ));
            chk($sformatf("v%0d_busy", i), 32'(flush_busy),    32'(vt[i].e_busy));
            if (vt[i].e_push) chk($sformatf("v%0d_pdata", i), lifo_push_data, vt[i].addr);
        end

        // saturation: 20 calls into a 16-deep stack, then 17 rets
        do_reset();
        for (int i = 0; i < 20; i++) do_call(32'h2000_0000 + 32'(i));
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        chk("sat_occ", 32'(occupancy), 32'd16);
        for (int k = 0; k < 16; k++) do_ret(1'b1, 32'h2000_0000 + 32'(19 - k));
        do_ret(1'b0, 32'h0);
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        chk("sat_occ_end", 32'(occupancy), 32'd0);

        // flush while a prediction is pending
        do_reset();
        for (int i = 0; i < 5; i++) do_call(32'h4000_0000 + 32'(i));
        drive(1'b1, 2'd2, 32'h0, 1'b0, 1'b0);
        chk("fl_ret_pop", 32'(lifo_pop_ack), 32'd1);
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        chk("fl_pv_before", 32'(pred_vld), 32'd1);
        chk("fl_pdata", pred_data, 32'h4000_0004);
        chk("fl_dec_ack", 32'(dec_ack), 32'd0);
        begin
            int busy_cnt = 0;
            int pop_cnt  = 0;
            bit done     = 0;
            drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
            chk("fl_pv_dropped", 32'(pred_vld), 32'd0);
            chk("fl_occ_start", 32'(occupancy), 32'd4);
            for (int c = 0; c < 40 && !done; c++) begin
                if (c > 0) drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
                if (flush_busy) begin
                    busy_cnt++;
                    if (lifo_pop_ack) pop_cnt++;
                end else begin
                    done = 1;
                end
            end
            chk("fl_done", 32'(done), 32'd1);
            chk("fl_busy_cycles", 32'(busy_cnt), 32'd5);
            chk("fl_pops", 32'(pop_cnt), 32'd4);
            chk("fl_occ_end", 32'(occupancy), 32'd0);
            chk("fl_idle_ack", 32'(dec_ack), 32'd1);
            chk("fl_pv_end", 32'(pred_vld), 32'd0);
        end

        // flush colliding with a CALL, then reset in the middle of the drain
        do_reset();
        for (int i = 0; i < 3; i++) do_call(32'h5000_0000 + 32'(i));
        drive(1'b1, 2'd1, 32'h5000_00FF, 1'b0, 1'b1);
        chk("fc_dec_ack", 32'(dec_ack), 32'd0);
        chk("fc_push", 32'(lifo_push_vld), 32'd0);
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        chk("fc_busy", 32'(flush_busy), 32'd1);
        chk("fc_occ", 32'(occupancy), 32'd3);
        chk("fc_pop", 32'(lifo_pop_ack), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("fc_busy_mid", 32'(flush_busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rf_busy", 32'(flush_busy), 32'd0);
        chk("rf_occ", 32'(occupancy), 32'd0);
        chk("rf_pv", 32'(pred_vld), 32'd0);
        chk("rf_hit", 32'(pred_hit), 32'd0);
        chk("rf_pop", 32'(lifo_pop_ack), 32'd0);
        chk("rf_ack", 32'(dec_ack), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
